opening_log_ctrl: RTL and testbench



---
 rtl/opening_log_ctrl.sv | 172 +++++++++++++++++
 tb/tb_opening_log_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/opening_log_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : opening_log_ctrl
//  Purpose  : Circular-log controller and arbiter for the opening-record memory
//             (append, indexed read-back by age, full-sweep clear).
//  Revision : 1.0  initial release
// ============================================================================
module opening_log_ctrl #(
   parameter int unsigned DEPTH = 512,
   parameter int unsigned AW    = 9,
   parameter int unsigned DW    = 17
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          log_req,
   input  logic [DW-1:0] log_data,
   output logic          log_ack,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_ofs,
   output logic          rd_valid,
   output logic          rd_err,
   output logic [DW-1:0] rd_data,
   input  logic          clr_req,
   output logic          clr_ack,
   output logic          busy,
   output logic [AW:0]   count,
   output logic [AW-1:0] mem_idx,
   output logic          mem_wr,
   output logic          mem_en,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_ERR   = 3'd3;
   localparam logic [2:0] S_CLEAR = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

   logic [2:0]    state_q,   state_d;
   logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
   logic [AW:0]   count_q,   count_d;
   logic [DW-1:0] rd_data_q, rd_data_d;
   logic          lww_q,     lww_d;
   logic [AW-1:0] clr_ptr_q, clr_ptr_d;
   logic          clr_ack_q, clr_ack_d;
   logic          ign_log_q, ign_log_d;
   logic          ign_rd_q,  ign_rd_d;

   logic w_log, w_rd, w_rd_ok;

   // A req still high in the IDLE cycle right after its pulse is the old request.
   assign w_log   = log_req && !ign_log_q;
   assign w_rd    = rd_req  && !ign_rd_q;
   assign w_rd_ok = ({1'b0, rd_ofs} < count_q);

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      rd_data_d = rd_data_q;
      lww_d     = lww_q;
      clr_ptr_d = clr_ptr_q;
      clr_ack_d = 1'b0;
      ign_log_d = (state_q == S_WRITE);
      ign_rd_d  = (state_q == S_DONE) || (state_q == S_ERR);
      case (state_q)
         S_IDLE: begin
            if (clr_req && !clr_ack_q) begin
               state_d   = S_CLEAR;
               clr_ptr_d = '0;
            end else if (w_log && w_rd) begin
               if (lww_q) state_d = w_rd_ok ? S_READ : S_ERR;
               else       state_d = S_WRITE;
            end else if (w_log) begin
               state_d = S_WRITE;
            end else if (w_rd) begin
               state_d = w_rd_ok ? S_READ : S_ERR;
            end
         end
         S_WRITE: begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = (count_q == C_FULL) ? count_q : count_q + (AW+1)'(1);
            lww_d    = 1'b1;
            state_d  = S_IDLE;
         end
         S_READ: begin
            rd_data_d = mem_rdata;
            lww_d     = 1'b0;
            state_d   = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         S_ERR: begin
            lww_d   = 1'b0;
            state_d = S_IDLE;
         end
         S_CLEAR: begin
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == C_LAST) begin
               wr_ptr_d  = '0;
               count_d   = '0;
               clr_ack_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
         lww_q     <= 1'b0;
         clr_ptr_q <= '0;
         clr_ack_q <= 1'b0;
         ign_log_q <= 1'b0;
         ign_rd_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
         lww_q     <= lww_d;
         clr_ptr_q <= clr_ptr_d;
         clr_ack_q <= clr_ack_d;
         ign_log_q <= ign_log_d;
         ign_rd_q  <= ign_rd_d;
      end
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_idx   = '0;
      mem_wdata = '0;
      case (state_q)
         S_WRITE: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_idx   = wr_ptr_q;
            mem_wdata = log_data;
         end
         S_READ: begin
            mem_en  = 1'b1;
            mem_idx = wr_ptr_q - AW'(1) - rd_ofs;
         end
         S_CLEAR: begin
            mem_en  = 1'b1;
            mem_wr  = 1'b1;
            mem_idx = clr_ptr_q;
         end
         default: ;
      endcase
   end

   assign log_ack  = (state_q == S_WRITE);
   assign rd_valid = (state_q == S_DONE);
   assign rd_err   = (state_q == S_ERR);
   assign clr_ack  = clr_ack_q;
   assign busy     = (state_q != S_IDLE);
   assign count    = count_q;
   assign rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_opening_log_ctrl.sv
`default_nettype none
// Testbench for opening_log_ctrl: behavioural circular-log model with a
// per-cycle comparator, directed scenarios and randomized append/read traffic.
module tb_opening_log_ctrl;

   localparam int DEPTH = 512;
   localparam int AW    = 9;
   localparam int DW    = 17;

   logic          clk = 1'b0;
   logic          reset;
   logic          log_req, rd_req, clr_req;
   logic [DW-1:0] log_data;
   logic [AW-1:0] rd_ofs;
   logic          log_ack, rd_valid, rd_err, clr_ack, busy;
   logic [DW-1:0] rd_data;
   logic [AW:0]   count;
   logic [AW-1:0] mem_idx;
   logic          mem_wr, mem_en;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   opening_log_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .log_req(log_req), .log_data(log_data), .log_ack(log_ack),
      .rd_req(rd_req), .rd_ofs(rd_ofs), .rd_valid(rd_valid), .rd_err(rd_err),
      .rd_data(rd_data),
      .clr_req(clr_req), .clr_ack(clr_ack), .busy(busy), .count(count),
      .mem_idx(mem_idx), .mem_wr(mem_wr), .mem_en(mem_en),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // the record memory itself: synchronous write, combinational read
   logic [DW-1:0] mem [0:DEPTH-1];
   always @(posedge clk) if (mem_en && mem_wr) mem[mem_idx] <= mem_wdata;
   assign mem_rdata = mem[mem_idx];

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_log [0:DEPTH-1];
   int            m_wp = 0, m_count = 0, m_clr = 0;
   logic [DW-1:0] m_rd = '0;

   always @(negedge clk) begin
      if (reset) begin
         m_wp = 0; m_count = 0; m_clr = 0; m_rd = '0;
      end else begin
         if (rd_valid) begin
            chk("rdv_in_range", int'(rd_ofs) < m_count, 1);
            m_rd = m_log[(m_wp - 1 - int'(rd_ofs)) & (DEPTH - 1)];
         end
         if (clr_ack) begin
            chk("clr_sweep_len", m_clr, DEPTH);
            m_count = 0; m_wp = 0; m_clr = 0;
         end
         chk("count", count, m_count);
         chk("rd_data", rd_data, m_rd);
         chk("one_pulse", $countones({log_ack, rd_valid, rd_err, clr_ack}) <= 1, 1);
         if (!busy) chk("idle_mem_pins", {mem_en, mem_wr, mem_idx, mem_wdata}, 0);
         if (rd_err) chk("err_out_of_range", int'(rd_ofs) >= m_count, 1);
         if (log_ack) begin
            chk("wr_pins", {mem_en, mem_wr, mem_idx, mem_wdata},
                {2'b11, AW'(m_wp), log_data});
            m_log[m_wp] = log_data;
            m_wp = (m_wp + 1) % DEPTH;
            if (m_count < DEPTH) m_count++;
         end else if (mem_en && mem_wr) begin
            chk("clr_pins", {mem_idx, mem_wdata}, {AW'(m_clr), DW'(0)});
            chk("clr_in_range", m_clr < DEPTH, 1);
            m_clr++;
         end else if (mem_en) begin
            chk("rd_idx", mem_idx, (m_wp - 1 - int'(rd_ofs)) & (DEPTH - 1));
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic do_write(input logic [DW-1:0] d, output logic [AW-1:0] idx);
      int n = 0;
      log_req = 1'b1; log_data = d;
      do begin @(negedge clk); n++; end while (!log_ack && n < 64);
      chk("wr_latency", n - 1, 1);
      idx = mem_idx;
      @(posedge clk); #1 log_req = 1'b0; log_data = DW'($urandom);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [AW-1:0] ofs, output logic [DW-1:0] d,
                          output logic e);
      int   n = 0;
      logic exp_e = (int'(ofs) >= m_count);
      logic en_seen = 1'b0;
      rd_req = 1'b1; rd_ofs = ofs;
      do begin @(negedge clk); n++; en_seen |= mem_en; end
      while (!rd_valid && !rd_err && n < 64);
      e = rd_err; d = rd_data;
      chk("rd_kind", e, exp_e);
      chk("rd_latency", n - 1, exp_e ? 1 : 2);
      if (exp_e) chk("err_no_mem_access", en_seen, 0);
      @(posedge clk); #1 rd_req = 1'b0; rd_ofs = AW'($urandom);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] idx;
      logic [DW-1:0] d;
      logic          e;
      logic [3:0]    seq;
      int            n;
      reset = 1'b1; log_req = 0; rd_req = 0; clr_req = 0;
      log_data = '0; rd_ofs = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_state", {busy, log_ack, rd_valid, rd_err, clr_ack, count, rd_data}, 0);
      chk("reset_mem", {mem_en, mem_wr, mem_idx, mem_wdata}, 0);
      @(posedge clk); #1;

      // three appends
      do_write(17'h00011, idx); chk("wr0_idx", idx, 0);
      do_write(17'h00022, idx); chk("wr1_idx", idx, 1);
      do_write(17'h00033, idx); chk("wr2_idx", idx, 2);
      chk("count3", count, 3);

      do_read(0, d, e); chk("rd_ofs0", d, 17'h00033);
      do_read(2, d, e); chk("rd_ofs2", d, 17'h00011);
      do_read(3, d, e); chk("rd_ofs3_err", e, 1); chk("rd_hold", d, 17'h00011);

      // both requesters held: must alternate, starting with the append
      log_req = 1'b1; rd_req = 1'b1; rd_ofs = '0; log_data = 17'h0ABCD;
      seq = '0;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin @(negedge clk); n++; end
         while (!log_ack && !rd_valid && !rd_err && n < 64);
         seq[3 - k] = log_ack;
      end
      @(posedge clk); #1 log_req = 1'b0; rd_req = 1'b0;
      @(posedge clk); #1;
      chk("arb_order", seq, 4'b1010);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         int r = $urandom_range(0, 9);
         if (r < 5) do_write(DW'($urandom), idx);
         else if (r < 9) do_read(AW'($urandom_range(0, (m_count + 2 > DEPTH - 1) ? DEPTH - 1 : m_count + 2)), d, e);
         else begin @(posedge clk); #1; end
      end

      // wrap-around
      do_reset();
      for (int i = 0; i < 514; i++) do_write(DW'(i), idx);
      chk("wrap_count", count, 512);
      do_read(0, d, e);   chk("wrap_ofs0", d, 513);
      do_read(511, d, e); chk("wrap_ofs511", d, 2);
      do_write(17'h1F0F0, idx); chk("wrap_wr_ptr", idx, 2);

      // clear beats a concurrent append; append lands afterwards at 0
      do_reset();
      for (int i = 0; i < 5; i++) do_write(DW'(17'h100 + i), idx);
      clr_req = 1'b1; log_req = 1'b1; log_data = 17'h1ABCD;
      n = 0;
      do begin @(negedge clk); n++; chk("no_ack_in_clear", log_ack, 0); end
      while (!clr_ack && n < 1000);
      chk("clr_latency", n - 1, DEPTH + 1);
      chk("clr_count", count, 0);
      @(posedge clk); #1 clr_req = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!log_ack && n < 64);
      chk("post_clr_wr_seen", log_ack, 1);
      chk("post_clr_idx", mem_idx, 0);
      @(posedge clk); #1 log_req = 1'b0;
      @(posedge clk); #1;
      chk("post_clr_count", count, 1);
      do_read(0, d, e); chk("post_clr_rd", d, 17'h1ABCD);

      // reset during the sweep
      clr_req = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(mem_en && mem_wr && mem_idx == 9'd100) && n < 1000);
      chk("sweep_reached_100", mem_idx, 100);
      @(posedge clk); #1 reset = 1'b1; clr_req = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_state", {busy, mem_en, count}, 0);
      n = 0;
      for (int i = 0; i < 600; i++) begin @(negedge clk); if (clr_ack) n++; end
      chk("abort_no_clr_ack", n, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
